// File: rtl/hydra_pkg.sv
// Shared write-path constants and types for the SRAM match scheduler.
package hydra_pkg;
    localparam int PORT_NUM = 16;
    localparam int SRAM_NUM = 32;
    localparam int PORT_W   = $clog2(PORT_NUM);
    localparam int SRAM_W   = $clog2(SRAM_NUM);

    typedef logic [SRAM_W:0] sram_idx_t;

    localparam sram_idx_t SRAM_NONE = 6'd32;

    // An index names a real bank only when its top bit is clear.
    function automatic logic sram_is_real(input sram_idx_t s);
        return ~s[SRAM_W];
    endfunction
endpackage

// File: rtl/sram_match_scheduler_if.sv
// Matcher-to-scheduler bus; sram_mask exists only when SRAM_MASK_EN is defined.
interface sram_match_scheduler_if;
    import hydra_pkg::*;

    logic                         scan_en;
    logic [PORT_NUM*SRAM_W-1:0]   match_sram;
    logic [PORT_NUM-1:0]          accessible;
    logic [PORT_NUM-1:0]          match_suc;
    logic [PORT_NUM*(SRAM_W+1)-1:0] match_best_sram;
    logic [PORT_NUM-1:0]          release_req;
    logic [PORT_NUM-1:0]          grant;
    logic [PORT_NUM-1:0]          nack;
    logic [PORT_NUM*(SRAM_W+1)-1:0] owned_sram;
    logic [SRAM_NUM-1:0]          busy_vec;
`ifdef SRAM_MASK_EN
    logic [SRAM_NUM-1:0]          sram_mask;

    modport slave  (input  scan_en, match_suc, match_best_sram, release_req, sram_mask,
                    output match_sram, accessible, grant, nack, owned_sram, busy_vec);
    modport master (output scan_en, match_suc, match_best_sram, release_req, sram_mask,
                    input  match_sram, accessible, grant, nack, owned_sram, busy_vec);
`else
    modport slave  (input  scan_en, match_suc, match_best_sram, release_req,
                    output match_sram, accessible, grant, nack, owned_sram, busy_vec);
    modport master (output scan_en, match_suc, match_best_sram, release_req,
                    input  match_sram, accessible, grant, nack, owned_sram, busy_vec);
`endif
endinterface

// File: rtl/rr_port_arbiter.sv
// Round-robin picker: grants the first requesting port at or after ptr, circularly.
module rr_port_arbiter
    import hydra_pkg::*;
#(
    parameter int N  = PORT_NUM,
    parameter int PW = PORT_W
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    // Walk the ports starting at ptr; only the first hit is granted.
    always_comb begin
        logic found;
        logic hit;
        int   idx;
        gnt   = '0;
        found = 1'b0;
        hit   = 1'b0;
        idx   = 0;
        for (int i = 0; i < N; i++) begin
            idx      = (int'(ptr) + i) % N;
            hit      = req[idx] & ~found;
            gnt[idx] = hit;
            found    = found | hit;
        end
    end
endmodule

// File: rtl/sram_match_scheduler.sv
// Central SRAM probe rotation, ownership table and round-robin commit arbiter.
// Optional build macro: SRAM_MASK_EN (adds a per-bank mask that blocks new commits).
module sram_match_scheduler
    import hydra_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    sram_match_scheduler_if.slave bus
);
    localparam int STRIDE = SRAM_NUM / PORT_NUM;
    localparam int IW     = SRAM_W + 1;

    logic [SRAM_W-1:0]   scan_base_r, scan_nxt_s;
    logic [PORT_W-1:0]   rr_ptr_r, rr_nxt_s;
    logic [SRAM_NUM-1:0] busy_r, busy_nxt_s, mask_s;
    logic [PORT_NUM-1:0] grant_r, nack_r, grant_s, nack_s;
    logic [PORT_NUM-1:0] valid_s, rel_ok_s, acc_s;
    logic [SRAM_W-1:0]   match_sram_r [PORT_NUM];
    logic [SRAM_W-1:0]   match_nxt_s  [PORT_NUM];
    sram_idx_t           owned_r      [PORT_NUM];
    sram_idx_t           owned_nxt_s  [PORT_NUM];
    sram_idx_t           best_s       [PORT_NUM];
    logic [PORT_NUM-1:0] req_mat_s    [SRAM_NUM];
    logic [PORT_NUM-1:0] gnt_mat_s    [SRAM_NUM];

`ifdef SRAM_MASK_EN
    assign mask_s = bus.sram_mask;
`else
    assign mask_s = '0;
`endif

    for (genvar p = 0; p < PORT_NUM; p++) begin : g_port
        assign best_s[p]                             = bus.match_best_sram[p*IW +: IW];
        assign bus.match_sram[p*SRAM_W +: SRAM_W]    = match_sram_r[p];
        assign bus.owned_sram[p*IW +: IW]            = owned_r[p];
        // Ports sit STRIDE banks apart, so probes never collide and each wraps mod 32.
        assign match_nxt_s[p] = scan_nxt_s + SRAM_W'(STRIDE * p);
        assign acc_s[p]       = ~busy_r[match_sram_r[p]] & ~mask_s[match_sram_r[p]];
    end

    assign bus.accessible = acc_s;
    assign bus.grant      = grant_r;
    assign bus.nack       = nack_r;
    assign bus.busy_vec   = busy_r;

    // Probe rotation base for the next cycle.
    always_comb begin
        if (bus.scan_en) begin
            scan_nxt_s = scan_base_r + SRAM_W'(1);
        end else begin
            scan_nxt_s = scan_base_r;
        end
    end

    // Request qualification against pre-update ownership state.
    always_comb begin
        valid_s  = '0;
        rel_ok_s = '0;
        for (int p = 0; p < PORT_NUM; p++) begin
            valid_s[p]  = bus.match_suc[p] & sram_is_real(best_s[p])
                        & ~busy_r[best_s[p][SRAM_W-1:0]]
                        & ~mask_s[best_s[p][SRAM_W-1:0]]
                        & (owned_r[p] == SRAM_NONE);
            rel_ok_s[p] = bus.release_req[p] & (owned_r[p] != SRAM_NONE);
        end
    end

    // Group valid requests by the bank they name.
    always_comb begin
        for (int s = 0; s < SRAM_NUM; s++) begin
            req_mat_s[s] = '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                req_mat_s[s][p] = valid_s[p] & (best_s[p][SRAM_W-1:0] == SRAM_W'(s));
            end
        end
    end

    for (genvar s = 0; s < SRAM_NUM; s++) begin : g_arb
        rr_port_arbiter #(.N(PORT_NUM), .PW(PORT_W)) u_arb (
            .req (req_mat_s[s]),
            .ptr (rr_ptr_r),
            .gnt (gnt_mat_s[s])
        );
    end

    // Merge per-bank winners; every other requester is refused.
    always_comb begin
        grant_s  = '0;
        rr_nxt_s = rr_ptr_r;
        for (int s = 0; s < SRAM_NUM; s++) begin
            grant_s = grant_s | gnt_mat_s[s];
        end
        nack_s = bus.match_suc & ~grant_s;
        for (int p = 0; p < PORT_NUM; p++) begin
            rr_nxt_s = grant_s[p] ? PORT_W'((p + 1) % PORT_NUM) : rr_nxt_s;
        end
    end

    // Ownership table update; a grant needs owned==NONE and a release needs owned!=NONE,
    // so the two never touch the same port or bank in one cycle.
    always_comb begin
        busy_nxt_s = busy_r;
        for (int p = 0; p < PORT_NUM; p++) begin
            busy_nxt_s[owned_r[p][SRAM_W-1:0]] = busy_nxt_s[owned_r[p][SRAM_W-1:0]] & ~rel_ok_s[p];
        end
        for (int p = 0; p < PORT_NUM; p++) begin
            busy_nxt_s[best_s[p][SRAM_W-1:0]] = busy_nxt_s[best_s[p][SRAM_W-1:0]] | grant_s[p];
            if (grant_s[p]) begin
                owned_nxt_s[p] = {1'b0, best_s[p][SRAM_W-1:0]};
            end else if (rel_ok_s[p]) begin
                owned_nxt_s[p] = SRAM_NONE;
            end else begin
                owned_nxt_s[p] = owned_r[p];
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_base_r <= '0;
            rr_ptr_r    <= '0;
            busy_r      <= '0;
            grant_r     <= '0;
            nack_r      <= '0;
            for (int p = 0; p < PORT_NUM; p++) begin
                match_sram_r[p] <= SRAM_W'(STRIDE * p);
                owned_r[p]      <= SRAM_NONE;
            end
        end else begin
            scan_base_r <= scan_nxt_s;
            rr_ptr_r    <= rr_nxt_s;
            busy_r      <= busy_nxt_s;
            grant_r     <= grant_s;
            nack_r      <= nack_s;
            for (int p = 0; p < PORT_NUM; p++) begin
                match_sram_r[p] <= match_nxt_s[p];
                owned_r[p]      <= owned_nxt_s[p];
            end
        end
    end
endmodule
